// File: rtl/img_rect_anim_ctrl_pkg.sv
// Shared types, FSM encoding, reset defaults and config-sanitising helpers
// for the bouncing-rectangle overlay controller.
package img_rect_anim_ctrl_pkg;

  localparam int CW = 11;
  localparam int SW = 4;

  typedef logic [CW-1:0] coord_t;
  typedef logic [SW-1:0] step_t;
  typedef logic [23:0]   color_t;

  typedef enum logic [1:0] {
    ST_RUN  = 2'd0,
    ST_HOLD = 2'd1,
    ST_LOAD = 2'd2
  } state_e;

  typedef struct packed {
    coord_t x;
    coord_t y;
    coord_t w;
    coord_t h;
    step_t  step;
    color_t color;
  } cfg_t;

  localparam coord_t DEF_W     = 11'd300;
  localparam coord_t DEF_H     = 11'd300;
  localparam step_t  DEF_STEP  = 4'd4;
  localparam color_t DEF_COLOR = 24'hFF00FF;

  // Size is forced into 1..lim so the box always exists and fits.
  function automatic coord_t fit_size(input coord_t s, input coord_t lim);
    coord_t r;
    if (s == '0)     r = coord_t'(1);
    else if (s > lim) r = lim;
    else             r = s;
    return r;
  endfunction

  // Position is pulled back so that pos+size never passes the active edge.
  function automatic coord_t fit_pos(input coord_t p, input coord_t s, input coord_t lim);
    logic [CW:0] sum;
    sum = {1'b0, p} + {1'b0, s};
    return (sum > {1'b0, lim}) ? coord_t'(lim - s) : p;
  endfunction

endpackage

// File: rtl/img_rect_anim_ctrl_if.sv
// Config handshake and rectangle overlay bus between the controller (slave)
// and its environment (master).
interface img_rect_anim_ctrl_if
  import img_rect_anim_ctrl_pkg::*;
  ;

  // Handshake: the master raises cfg_valid with stable cfg_* fields; a
  // transfer happens on any rising clk edge where cfg_valid && cfg_ready.
  // cfg_ready is low while an accepted config waits for its frame boundary.
  logic   cfg_valid;
  logic   cfg_ready;
  coord_t cfg_x;
  coord_t cfg_y;
  coord_t cfg_w;
  coord_t cfg_h;
  step_t  cfg_step;
  color_t cfg_color;

  coord_t rect_x1;
  coord_t rect_y1;
  coord_t rect_x2;
  coord_t rect_y2;
  color_t rect_color;
  logic   bounce_x;
  logic   bounce_y;

  modport master (
    output cfg_valid, cfg_x, cfg_y, cfg_w, cfg_h, cfg_step, cfg_color,
    input  cfg_ready, rect_x1, rect_y1, rect_x2, rect_y2, rect_color,
    input  bounce_x, bounce_y
  );

  modport slave (
    input  cfg_valid, cfg_x, cfg_y, cfg_w, cfg_h, cfg_step, cfg_color,
    output cfg_ready, rect_x1, rect_y1, rect_x2, rect_y2, rect_color,
    output bounce_x, bounce_y
  );

endinterface

// File: rtl/img_rect_anim_ctrl_rect_axis_step.sv
// One-axis bounce step: advances a position by step in the current direction
// and reflects at 0 or at LIMIT-size, flagging the reflection.
module rect_axis_step
  import img_rect_anim_ctrl_pkg::*;
#(
  parameter coord_t LIMIT = 11'd1280
) (
  input  coord_t pos_i,
  input  coord_t size_i,
  input  step_t  step_i,
  input  logic   dir_i,    // 0 = increasing, 1 = decreasing
  output coord_t pos_o,
  output logic   dir_o,
  output logic   bounce_o
);

  logic [CW:0] pos_w;
  logic [CW:0] size_w;
  logic [CW:0] step_w;
  logic [CW:0] lim_w;

  assign pos_w  = {1'b0, pos_i};
  assign size_w = {1'b0, size_i};
  assign step_w = {{(CW+1-SW){1'b0}}, step_i};
  assign lim_w  = {1'b0, LIMIT};

  always_comb begin
    pos_o    = pos_i;
    dir_o    = dir_i;
    bounce_o = 1'b0;
    if (!dir_i) begin
      if (pos_w + size_w + step_w > lim_w) begin
        pos_o    = coord_t'(LIMIT - size_i);
        dir_o    = 1'b1;
        bounce_o = 1'b1;
      end else begin
        pos_o = pos_i + coord_t'(step_i);
      end
    end else begin
      if (pos_w < step_w) begin
        pos_o    = '0;
        dir_o    = 1'b0;
        bounce_o = 1'b1;
      end else begin
        pos_o = pos_i - coord_t'(step_i);
      end
    end
  end

endmodule

// File: rtl/img_rect_anim_ctrl.sv
// Frame-synchronous bouncing-rectangle controller with a frame-boundary config
// shadow. Optional macro RECT_COLOR_CYCLE_EN rotates the colour on each bounce.
module img_rect_anim_ctrl
  import img_rect_anim_ctrl_pkg::*;
#(
  parameter coord_t H_ACT = 11'd1280,
  parameter coord_t V_ACT = 11'd720
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        vs_i,
  input  logic                        run_en,
  img_rect_anim_ctrl_if.slave         bus,
  output state_e                      state_o
);

  state_e state_q, state_d;
  logic   vs_q, fe_q;
  coord_t x1_q, x1_d, y1_q, y1_d, w_q, w_d, h_q, h_d;
  coord_t x2_q, x2_d, y2_q, y2_d;
  step_t  step_q, step_d;
  color_t color_q, color_d;
  logic   dirx_q, dirx_d, diry_q, diry_d;
  logic   pend_q, pend_d;
  logic   bx_q, bx_d, by_q, by_d;
  cfg_t   sh_q, sh_d;

  coord_t nx_x, nx_y;
  logic   nd_x, nd_y, nb_x, nb_y;
  logic   cfg_fire;

  assign cfg_fire = bus.cfg_valid & ~pend_q;

  rect_axis_step #(.LIMIT(H_ACT)) u_axis_x (
    .pos_i(x1_q), .size_i(w_q), .step_i(step_q), .dir_i(dirx_q),
    .pos_o(nx_x), .dir_o(nd_x), .bounce_o(nb_x)
  );

  rect_axis_step #(.LIMIT(V_ACT)) u_axis_y (
    .pos_i(y1_q), .size_i(h_q), .step_i(step_q), .dir_i(diry_q),
    .pos_o(nx_y), .dir_o(nd_y), .bounce_o(nb_y)
  );

  always_comb begin
    state_d = pend_q ? ST_LOAD : (run_en ? ST_RUN : ST_HOLD);
    x1_d    = x1_q;
    y1_d    = y1_q;
    w_d     = w_q;
    h_d     = h_q;
    step_d  = step_q;
    color_d = color_q;
    dirx_d  = dirx_q;
    diry_d  = diry_q;
    pend_d  = pend_q;
    sh_d    = sh_q;
    bx_d    = 1'b0;
    by_d    = 1'b0;

    if (cfg_fire) begin
      sh_d   = '{x: bus.cfg_x, y: bus.cfg_y, w: bus.cfg_w, h: bus.cfg_h,
                 step: bus.cfg_step, color: bus.cfg_color};
      pend_d = 1'b1;
    end

    // The mode is sampled from the pre-handshake pending flag, so a config
    // accepted on the frame-edge cycle waits for the following frame.
    if (fe_q) begin
      case (state_d)
        ST_LOAD: begin
          w_d     = fit_size(sh_q.w, H_ACT);
          h_d     = fit_size(sh_q.h, V_ACT);
          x1_d    = fit_pos(sh_q.x, w_d, H_ACT);
          y1_d    = fit_pos(sh_q.y, h_d, V_ACT);
          step_d  = sh_q.step;
          color_d = sh_q.color;
          dirx_d  = 1'b0;
          diry_d  = 1'b0;
          pend_d  = 1'b0;
        end
        ST_RUN: begin
          x1_d   = nx_x;
          y1_d   = nx_y;
          dirx_d = nd_x;
          diry_d = nd_y;
          bx_d   = nb_x;
          by_d   = nb_y;
`ifdef RECT_COLOR_CYCLE_EN
          if (nb_x || nb_y) color_d = {color_q[15:0], color_q[23:16]};
`endif
        end
        default: ;
      endcase
    end

    x2_d = x1_d + w_d - 11'd1;
    y2_d = y1_d + h_d - 11'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_HOLD;
    else        state_q <= state_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vs_q    <= 1'b0;
      fe_q    <= 1'b0;
      x1_q    <= '0;
      y1_q    <= '0;
      w_q     <= DEF_W;
      h_q     <= DEF_H;
      x2_q    <= DEF_W - 11'd1;
      y2_q    <= DEF_H - 11'd1;
      step_q  <= DEF_STEP;
      color_q <= DEF_COLOR;
      dirx_q  <= 1'b0;
      diry_q  <= 1'b0;
      pend_q  <= 1'b0;
      sh_q    <= '0;
      bx_q    <= 1'b0;
      by_q    <= 1'b0;
    end else begin
      vs_q    <= vs_i;
      fe_q    <= vs_i & ~vs_q;
      x1_q    <= x1_d;
      y1_q    <= y1_d;
      w_q     <= w_d;
      h_q     <= h_d;
      x2_q    <= x2_d;
      y2_q    <= y2_d;
      step_q  <= step_d;
      color_q <= color_d;
      dirx_q  <= dirx_d;
      diry_q  <= diry_d;
      pend_q  <= pend_d;
      sh_q    <= sh_d;
      bx_q    <= bx_d;
      by_q    <= by_d;
    end
  end

  assign bus.cfg_ready  = ~pend_q;
  assign bus.rect_x1    = x1_q;
  assign bus.rect_y1    = y1_q;
  assign bus.rect_x2    = x2_q;
  assign bus.rect_y2    = y2_q;
  assign bus.rect_color = color_q;
  assign bus.bounce_x   = bx_q;
  assign bus.bounce_y   = by_q;
  assign state_o        = state_q;

endmodule

// File: tb/tb_img_rect_anim_ctrl.sv
// Bench for img_rect_anim_ctrl: directed scenarios plus random frames checked
// against a frame-level integer model of the bouncing box.
module tb_img_rect_anim_ctrl;
  import img_rect_anim_ctrl_pkg::*;

  localparam int H = 1280;
  localparam int V = 720;

  logic   clk = 1'b0;
  logic   rst_n = 1'b0;
  logic   vs_i = 1'b0;
  logic   run_en = 1'b0;
  state_e state_o;

  img_rect_anim_ctrl_if bus();

  img_rect_anim_ctrl #(.H_ACT(11'd1280), .V_ACT(11'd720)) dut (
    .clk(clk), .rst_n(rst_n), .vs_i(vs_i), .run_en(run_en),
    .bus(bus), .state_o(state_o)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // ---------------- reference model ----------------
  int          m_x, m_y, m_w, m_h, m_step, m_dx, m_dy;
  logic [23:0] m_color;
  bit          m_pend, m_bx, m_by;
  int          s_x, s_y, s_w, s_h, s_step;
  logic [23:0] s_color;
  logic [67:0] m_last;

  // ---------------- scoreboard ----------------
  logic [67:0] exp_q[$];
  int          n_vec = 0;
  int          n_err = 0;
  logic        obs_bx, obs_by;

  // cfg offer currently being driven
  logic [10:0] c_x, c_y, c_w, c_h;
  logic [3:0]  c_step;
  logic [23:0] c_color;

  task automatic check(input string tag, input logic [67:0] obs, input logic [67:0] exp_v);
    n_vec++;
    if (obs !== exp_v) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp_v);
    end
  endtask

  function automatic logic [67:0] pack(input int x, input int y, input int w, input int h,
                                       input logic [23:0] c);
    return {11'(x), 11'(y), 11'(x + w - 1), 11'(y + h - 1), c};
  endfunction

  function automatic logic [67:0] obs_pack();
    return {bus.rect_x1, bus.rect_y1, bus.rect_x2, bus.rect_y2, bus.rect_color};
  endfunction

  task automatic model_reset();
    m_x = 0; m_y = 0; m_w = 300; m_h = 300; m_step = 4;
    m_dx = 1; m_dy = 1; m_color = 24'hFF00FF;
    m_pend = 0; m_bx = 0; m_by = 0;
    m_last = pack(0, 0, 300, 300, 24'hFF00FF);
    exp_q.delete();
  endtask

  task automatic move_axis(input int p, input int d, input int s, input int st, input int lim,
                           output int p_n, output int d_n, output bit b);
    p_n = p; d_n = d; b = 0;
    if (d > 0) begin
      if (p + s + st > lim) begin p_n = lim - s; d_n = -1; b = 1; end
      else p_n = p + st;
    end else begin
      if (p - st < 0) begin p_n = 0; d_n = 1; b = 1; end
      else p_n = p - st;
    end
  endtask

  task automatic model_frame();
    int px, py, dx, dy;
    bit bx, by;
    m_bx = 0; m_by = 0;
    if (m_pend) begin
      m_w = (s_w == 0) ? 1 : ((s_w > H) ? H : s_w);
      m_h = (s_h == 0) ? 1 : ((s_h > V) ? V : s_h);
      m_x = (s_x + m_w > H) ? H - m_w : s_x;
      m_y = (s_y + m_h > V) ? V - m_h : s_y;
      m_step = s_step; m_color = s_color;
      m_dx = 1; m_dy = 1; m_pend = 0;
    end else if (run_en) begin
      move_axis(m_x, m_dx, m_w, m_step, H, px, dx, bx);
      move_axis(m_y, m_dy, m_h, m_step, V, py, dy, by);
      m_x = px; m_dx = dx; m_bx = bx;
      m_y = py; m_dy = dy; m_by = by;
`ifdef RECT_COLOR_CYCLE_EN
      if (bx || by) m_color = {m_color[15:0], m_color[23:16]};
`endif
    end
    m_last = pack(m_x, m_y, m_w, m_h, m_color);
    exp_q.push_back(m_last);
  endtask

  // ---------------- drivers ----------------
  task automatic drive_cfg_fields();
    bus.cfg_x = c_x; bus.cfg_y = c_y; bus.cfg_w = c_w; bus.cfg_h = c_h;
    bus.cfg_step = c_step; bus.cfg_color = c_color;
  endtask

  task automatic capture_cfg();
    m_pend = 1;
    s_x = int'(c_x); s_y = int'(c_y); s_w = int'(c_w); s_h = int'(c_h);
    s_step = int'(c_step); s_color = c_color;
  endtask

  task automatic rand_cfg();
    int mode;
    mode = $urandom_range(0, 3);
    c_w = (mode == 0) ? 11'd0 : (mode == 1) ? 11'($urandom_range(1300, 2047))
                                            : 11'($urandom_range(1, 400));
    mode = $urandom_range(0, 3);
    c_h = (mode == 0) ? 11'd0 : (mode == 1) ? 11'($urandom_range(730, 2047))
                                            : 11'($urandom_range(1, 400));
    c_x = 11'($urandom_range(0, 2047));
    c_y = 11'($urandom_range(0, 2047));
    c_step = 4'($urandom_range(0, 15));
    c_color = 24'($urandom);
  endtask

  // One-cycle offer between frames; ignored by the DUT if a config is pending.
  task automatic offer_cfg();
    check("ready_pre", 68'(bus.cfg_ready), 68'(!m_pend));
    drive_cfg_fields();
    bus.cfg_valid = 1'b1;
    tick();
    bus.cfg_valid = 1'b0;
    if (!m_pend) capture_cfg();
    check("ready_post", 68'(bus.cfg_ready), 68'(!m_pend));
  endtask

  task automatic run_frame(input bit cfg_at_fe);
    bit was_pend;
    was_pend = m_pend;
    vs_i = 1'b1;
    tick();                       // frame-edge cycle
    model_frame();
    if (cfg_at_fe) begin
      drive_cfg_fields();
      bus.cfg_valid = 1'b1;
    end
    tick();                       // outputs reflect the frame action
    if (cfg_at_fe) begin
      bus.cfg_valid = 1'b0;
      if (!was_pend) capture_cfg();
    end
    obs_bx = bus.bounce_x;
    obs_by = bus.bounce_y;
    check("frame", obs_pack(), exp_q.pop_front());
    check("bounce", {66'b0, obs_bx, obs_by}, {66'b0, m_bx, m_by});
    tick();
    check("bounce_clr", {66'b0, bus.bounce_x, bus.bounce_y}, 68'(0));
    repeat ($urandom_range(1, 4)) tick();
    check("vs_held", obs_pack(), m_last);
    vs_i = 1'b0;
    repeat ($urandom_range(2, 6)) tick();
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int g;
    bus.cfg_valid = 1'b0;
    c_x = '0; c_y = '0; c_w = '0; c_h = '0; c_step = '0; c_color = '0;
    drive_cfg_fields();
    model_reset();
    repeat (3) tick();
    check("reset_out", obs_pack(), pack(0, 0, 300, 300, 24'hFF00FF));
    check("reset_rdy", 68'(bus.cfg_ready), 68'(1));
    check("reset_bnc", {66'b0, bus.bounce_x, bus.bounce_y}, 68'(0));
    rst_n = 1'b1;
    tick();

    // three frames from reset
    run_en = 1'b1;
    repeat (3) run_frame(1'b0);
    check("x1_12", 68'(bus.rect_x1), 68'(12));
    check("y1_12", 68'(bus.rect_y1), 68'(12));
    check("x2_311", 68'(bus.rect_x2), 68'(311));
    check("y2_311", 68'(bus.rect_y2), 68'(311));

    // right-edge reflection
    g = 0;
    while (m_x != 980 && g < 400) begin run_frame(1'b0); g++; end
    check("reach_980", 68'(bus.rect_x1), 68'(980));
    run_frame(1'b0);
    check("edge_x1", 68'(bus.rect_x1), 68'(980));
    check("edge_bx", 68'(obs_bx), 68'(1));
    run_frame(1'b0);
    check("back_x1", 68'(bus.rect_x1), 68'(976));

    // clamped config applied at next frame
    c_x = 11'd1270; c_y = 11'd10; c_w = 11'd20; c_h = 11'd20; c_step = 4'd2; c_color = 24'h123456;
    offer_cfg();
    repeat (3) tick();
    check("cfg_wait_rdy", 68'(bus.cfg_ready), 68'(0));
    run_frame(1'b0);
    check("cfg_x1", 68'(bus.rect_x1), 68'(1260));
    check("cfg_y1", 68'(bus.rect_y1), 68'(10));
    check("cfg_rdy", 68'(bus.cfg_ready), 68'(1));

    // frozen frames, config offered while frozen, second offer ignored
    run_en = 1'b0;
    repeat (2) run_frame(1'b0);
    rand_cfg();
    offer_cfg();
    rand_cfg();
    offer_cfg();
    repeat (3) run_frame(1'b0);

    // config offered on the frame-edge cycle
    run_en = 1'b1;
    run_frame(1'b0);
    rand_cfg();
    run_frame(1'b1);
    run_frame(1'b0);
    run_frame(1'b0);

    // random frames
    for (int i = 0; i < 150; i++) begin
      run_en = ($urandom_range(0, 4) != 0);
      if ($urandom_range(0, 9) < 3) begin rand_cfg(); offer_cfg(); end
      if ($urandom_range(0, 9) == 0) begin rand_cfg(); run_frame(1'b1); end
      else run_frame(1'b0);
    end

    // reset while a config is pending
    run_en = 1'b1;
    rand_cfg();
    if (!m_pend) offer_cfg();
    rst_n = 1'b0;
    #1;
    check("rst_out", obs_pack(), pack(0, 0, 300, 300, 24'hFF00FF));
    check("rst_rdy", 68'(bus.cfg_ready), 68'(1));
    tick();
    rst_n = 1'b1;
    model_reset();
    tick();
    run_frame(1'b0);
    check("rst_x1", 68'(bus.rect_x1), 68'(4));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
